mem_arbiter: RTL
================

# mem_arbiter

Single-port RAM controller that shares the byte-wide main-memory bus between the instruction cache (32-bit fetches) and the load/store buffer (1/2/4-byte loads and stores). Sits between ICache/LSB and the top-level RAM interface. Serialises each request into byte transfers, assembles read data little-endian, and honours pipeline flush and the global ready stall.

## Interface
Parameters:
- ADDR_W, 32, address width of all address ports.

Ports:
- clk_in  in  1  system clock; all state on rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global ready; low freezes all state.
- clear  in  1  pipeline flush from ROB.
- io_buffer_full  in  1  UART output buffer full.
- ic_req  in  1  ICache fetch request, held until ic_done.
- ic_addr  in  32  fetch address, word-aligned.
- ic_done  out  1  one-cycle pulse; ic_data valid.
- ic_data  out  32  fetched word.
- lsb_req  in  1  LSB request, held until lsb_done.
- lsb_we  in  1  1 = store, 0 = load.
- lsb_len  in  3  byte count: 1, 2 or 4; other values are illegal.
- lsb_addr  in  32  byte address.
- lsb_wdata  in  32  store data; byte i is bits [8i+7:8i].
- lsb_done  out  1  one-cycle pulse; load data valid or store complete.
- lsb_rdata  out  32  load data, zero-extended; LSB performs sign extension.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  RAM write strobe (1 = write).

## Operation
- States: IDLE, READ, WRITE, DONE.
- Reset values:
  - state = IDLE.
  - mem_a = 0, mem_dout = 0, mem_wr = 0.
  - ic_done = 0, lsb_done = 0.
  - ic_data = 0, lsb_rdata = 0.
  - byte counter = 0.
- IDLE arbitration: lsb_req has priority over ic_req. Grant latches owner, address, length (4 for ICache) and wdata. Next state is READ, or WRITE when lsb_we = 1.
- READ:
  - mem_a = base + cnt while cnt < len.
  - Byte captured from mem_din goes to data[8k+7:8k], k = cnt − 1.
  - After the last byte: the owner's done pulses, data is driven, state → DONE.
- WRITE:
  - mem_a = base + cnt, mem_dout = wdata byte cnt, mem_wr = 1, one byte per cycle.
  - After the last byte: mem_wr = 0, lsb_done pulses, state → DONE.
- DONE: one cycle; requests ignored; → IDLE. The requester drops req on seeing done.
- Address arithmetic: 32-bit modulo addition; wrap from 0xFFFFFFFF to 0 is legal.
- clear:
  - In IDLE, READ or DONE: read aborts, state → IDLE, mem_wr = 0, no done pulse. A request arriving together with clear is not granted that cycle.
  - In WRITE: clear is ignored. A store in flight is committed and runs to completion with lsb_done.
- rdy_in = 0: all registers hold and mem_wr is forced to 0. Bytes resume on the next ready cycle.
- clear has priority over rdy_in = 0; rst_in has priority over everything.

## Timing
- Grant edge G. Byte i address is driven during cycle G+1+i.
- RAM data for that address appears one cycle later and is captured at the following edge.
- Read of n bytes: done high during cycle G+n+2. A 4-byte fetch has done 6 cycles after req is sampled.
- Write of n bytes: mem_wr high during cycles G+1 … G+n; lsb_done high during cycle G+n+1.
- Back-to-back throughput: every request costs at least one DONE cycle plus one IDLE sampling cycle.

## Configuration
- MEM_IO_STALL_EN defined:
  - An LSB store with lsb_addr[17:16] = 2'b11 is not granted while io_buffer_full = 1; a pending ic_req may be granted instead.
  - Stall is checked at every byte of such a store: mem_wr stays 0 and cnt holds while io_buffer_full = 1.
- Not defined: io_buffer_full is ignored entirely.

## Structure
- Shared package / defines header holds:
  - state encodings;
  - IO region selector (bits [17:16] = 2'b11);
  - length constants LEN_B = 1, LEN_H = 2, LEN_W = 4;
  - existing `zero/`one macros.
- No sub-module required. Byte-lane assembly and counter stay inline in one module.

## Test plan
- ic_req, ic_addr = 0x100, RAM[0x100..0x103] = 13 00 A0 04 -> mem_a sequence 0x100–0x103, ic_done once with ic_data = 0x04A00013.
- ic_req and lsb_req (load, len 2, addr 0x201, bytes FE FF) in same cycle -> LSB served first, lsb_rdata = 0x0000FFFE; then fetch starts with no ic_done in between.
- Store len 4, addr 0x300, wdata 0xDEADBEEF -> mem_wr high 4 cycles with bytes EF BE AD DE at 0x300–0x303; lsb_done once; clear asserted mid-store -> all 4 bytes still written.
- 4-byte fetch with clear after byte 2 -> state IDLE next cycle, no ic_done, mem_wr never asserted.
- rdy_in low for 3 cycles during a 4-byte read -> mem_a and counter frozen; result identical to unstalled run, done delayed by exactly 3 cycles.
- MEM_IO_STALL_EN defined: store len 1 to 0x30000 with io_buffer_full = 1 for 5 cycles -> no mem_wr during stall; write issued the cycle after io_buffer_full falls.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the byte-wide main-memory arbiter.
// Holds FSM state encodings, transfer length constants, the IO region
// selector and the `ZERO/`ONE helper macros used across the memory blocks.
// The optional MEM_IO_STALL_EN macro (see mem_arbiter.sv) uses is_io().

`ifndef ZERO
`define ZERO 1'b0
`endif
`ifndef ONE
`define ONE 1'b1
`endif

package mem_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Address bits [17:16] equal to this select the memory-mapped IO region
  localparam logic [1:0] IO_SEL = 2'b11;

  localparam logic [CNT_W-1:0] LEN_B = 3'd1;
  localparam logic [CNT_W-1:0] LEN_H = 3'd2;
  localparam logic [CNT_W-1:0] LEN_W = 3'd4;

  function automatic logic is_io(input logic [1:0] sel);
    return sel == IO_SEL;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM bus between ICache word fetches and
// LSB 1/2/4-byte loads/stores. Each request is serialised into byte
// transfers; read bytes are assembled little-endian. LSB wins arbitration.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global freeze), clear (flush)
//   io_buffer_full            UART buffer full (used only with MEM_IO_STALL_EN)
//   ic_req/ic_addr            fetch request -> ic_done pulse, ic_data word
//   lsb_req/we/len/addr/wdata load/store request -> lsb_done pulse, lsb_rdata
//   mem_din/mem_dout/mem_a/mem_wr  byte-wide RAM interface
//
// Build option: define MEM_IO_STALL_EN to hold stores to the IO region
// (addr[17:16] = 2'b11) while io_buffer_full is high.

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              io_buffer_full,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_data,
  input  logic              lsb_req,
  input  logic              lsb_we,
  input  logic [CNT_W-1:0]  lsb_len,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [DATA_W-1:0] lsb_wdata,
  output logic              lsb_done,
  output logic [DATA_W-1:0] lsb_rdata,
  input  logic [BYTE_W-1:0] mem_din,
  output logic [BYTE_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  state_t              state_q, state_n;
  logic                owner_lsb_q, owner_lsb_n;
  logic [ADDR_W-1:0]   base_q, base_n;
  logic [CNT_W-1:0]    len_q, len_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [DATA_W-1:0]   buf_q, buf_n;
  logic                wr_q, wr_n;
  logic [ADDR_W-1:0]   mem_a_n;
  logic [BYTE_W-1:0]   mem_dout_n;
  logic                ic_done_n, lsb_done_n;
  logic [DATA_W-1:0]   ic_data_n, lsb_rdata_n;

  logic [CNT_W-1:0]    cnt_inc;
  logic [1:0]          rd_lane;
  logic [1:0]          wr_lane;
  logic                len_ok;
  logic [CNT_W-1:0]    len_sel;
  logic                lsb_blocked;
  logic                io_hold;
  logic                flush;
  logic                en;

  assign cnt_inc = cnt_q + 3'd1;
  // Byte captured now belongs to the address issued two edges ago
  assign rd_lane = 2'(cnt_q - 3'd1);
  assign wr_lane = 2'(cnt_inc);

  // Illegal lengths are reduced to a single byte so a transfer always ends
  assign len_ok  = (lsb_len == LEN_B) || (lsb_len == LEN_H) || (lsb_len == LEN_W);
  assign len_sel = len_ok ? lsb_len : LEN_B;

`ifdef MEM_IO_STALL_EN
  assign lsb_blocked = lsb_we && is_io(lsb_addr[17:16]) && io_buffer_full;
  assign io_hold     = (state_q == WRITE) && is_io(base_q[17:16]) && io_buffer_full;
`else
  // io_buffer_full has no effect in this build
  logic unused_io;
  assign unused_io   = io_buffer_full ^ is_io(lsb_addr[17:16]);
  assign lsb_blocked = `ZERO;
  assign io_hold     = `ZERO;
`endif

  // A committed store ignores the flush; everything else aborts to IDLE
  assign flush = clear && (state_q != WRITE);
  // Flush overrides the global stall
  assign en    = rdy_in || flush;

  // Write strobe is suppressed during stalls without disturbing held state
  assign mem_wr = wr_q && rdy_in && !io_hold;

  // Next-state and datapath update
  always_comb begin
    state_n     = state_q;
    owner_lsb_n = owner_lsb_q;
    base_n      = base_q;
    len_n       = len_q;
    wdata_n     = wdata_q;
    cnt_n       = cnt_q;
    buf_n       = buf_q;
    wr_n        = wr_q;
    mem_a_n     = mem_a;
    mem_dout_n  = mem_dout;
    ic_done_n   = `ZERO;
    lsb_done_n  = `ZERO;
    ic_data_n   = ic_data;
    lsb_rdata_n = lsb_rdata;

    if (flush) begin
      state_n = IDLE;
      wr_n    = `ZERO;
    end else begin
      unique case (state_q)
        IDLE: begin
          wr_n = `ZERO;
          if (lsb_req && !lsb_blocked) begin
            owner_lsb_n = `ONE;
            base_n      = lsb_addr;
            len_n       = len_sel;
            wdata_n     = lsb_wdata;
            cnt_n       = '0;
            buf_n       = '0;
            mem_a_n     = lsb_addr;
            if (lsb_we) begin
              wr_n       = `ONE;
              mem_dout_n = lsb_wdata[BYTE_W-1:0];
              state_n    = WRITE;
            end else begin
              state_n    = READ;
            end
          end else if (ic_req) begin
            owner_lsb_n = `ZERO;
            base_n      = ic_addr;
            len_n       = LEN_W;
            cnt_n       = '0;
            buf_n       = '0;
            mem_a_n     = ic_addr;
            state_n     = READ;
          end
        end

        READ: begin
          if (cnt_q != '0) begin
            buf_n[{rd_lane, 3'b000} +: BYTE_W] = mem_din;
          end
          cnt_n = cnt_inc;
          if (cnt_inc < len_q) begin
            mem_a_n = base_q + ADDR_W'(cnt_inc);
          end
          if (cnt_q == len_q) begin
            state_n = DONE;
            if (owner_lsb_q) begin
              lsb_done_n  = `ONE;
              lsb_rdata_n = buf_n;
            end else begin
              ic_done_n   = `ONE;
              ic_data_n   = buf_n;
            end
          end
        end

        WRITE: begin
          if (!io_hold) begin
            if (cnt_inc < len_q) begin
              cnt_n      = cnt_inc;
              mem_a_n    = base_q + ADDR_W'(cnt_inc);
              mem_dout_n = wdata_q[{wr_lane, 3'b000} +: BYTE_W];
              wr_n       = `ONE;
            end else begin
              wr_n       = `ZERO;
              lsb_done_n = `ONE;
              state_n    = DONE;
            end
          end
        end

        DONE: begin
          state_n = IDLE;
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else if (en) begin
      state_q <= state_n;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      owner_lsb_q <= `ZERO;
      base_q      <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      wr_q        <= `ZERO;
      mem_a       <= '0;
      mem_dout    <= '0;
      ic_done     <= `ZERO;
      lsb_done    <= `ZERO;
      ic_data     <= '0;
      lsb_rdata   <= '0;
    end else if (en) begin
      owner_lsb_q <= owner_lsb_n;
      base_q      <= base_n;
      len_q       <= len_n;
      wdata_q     <= wdata_n;
      cnt_q       <= cnt_n;
      buf_q       <= buf_n;
      wr_q        <= wr_n;
      mem_a       <= mem_a_n;
      mem_dout    <= mem_dout_n;
      ic_done     <= ic_done_n;
      lsb_done    <= lsb_done_n;
      ic_data     <= ic_data_n;
      lsb_rdata   <= lsb_rdata_n;
    end
  end

endmodule
